// File: rtl/track_pkg.sv
// Shared definitions for the handwriting canvas: canvas geometry, pen
// coordinate width and the controller state encoding.
package track_pkg;

    localparam int unsigned CANVAS_W    = 52;
    localparam int unsigned CANVAS_H    = 52;
    localparam int unsigned CANVAS_BITS = CANVAS_W * CANVAS_H;
    localparam int unsigned COORD_W     = 6;

    typedef enum logic [1:0] {
        ST_DRAW   = 2'd0,
        ST_SUBMIT = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

endpackage

// File: rtl/track_canvas_if.sv
// Pen / control / predictor bus between the canvas and its environment.
//   master : pen sampler and predictor side (drives pen_*, clear, submit, predict_finish)
//   slave  : track_canvas (drives track_input, predict_start, busy, canvas_empty, timeout)
interface track_canvas_if
    import track_pkg::*;
#(
    parameter int unsigned BITS = CANVAS_BITS
) ();

    logic               pen_valid;
    logic               pen_down;
    logic [COORD_W-1:0] pen_x;
    logic [COORD_W-1:0] pen_y;
    logic               clear;
    logic               submit;
    logic               predict_finish;
    logic [BITS-1:0]    track_input;
    logic               predict_start;
    logic               busy;
    logic               canvas_empty;
    logic               timeout;

    modport master (
        output pen_valid, pen_down, pen_x, pen_y, clear, submit, predict_finish,
        input  track_input, predict_start, busy, canvas_empty, timeout
    );

    modport slave (
        input  pen_valid, pen_down, pen_x, pen_y, clear, submit, predict_finish,
        output track_input, predict_start, busy, canvas_empty, timeout
    );

endinterface

// File: rtl/track_brush_mask.sv
// Combinational brush footprint: (i_x,i_y) -> W*H mask with a square brush of
// radius BRUSH_R, cells off the canvas dropped. An off-canvas centre yields an
// all-zero mask and o_in_range=0.
//   i_x, i_y    : brush centre column / row
//   o_mask      : bit y*W+x set for every inked cell
//   o_in_range  : centre lies on the canvas
module track_brush_mask
    import track_pkg::*;
#(
    parameter int unsigned W       = CANVAS_W,
    parameter int unsigned H       = CANVAS_H,
    parameter int unsigned BRUSH_R = 1
) (
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    output logic [W*H-1:0]     o_mask,
    output logic               o_in_range
);

    localparam int unsigned IDX_W = $clog2(W * H);
    localparam int          R     = int'(BRUSH_R);

    int w_cx;
    int w_cy;

    always_comb begin
        o_mask     = '0;
        w_cx       = 0;
        w_cy       = 0;
        o_in_range = (32'(i_x) < W) && (32'(i_y) < H);
        if (o_in_range) begin
            for (int dy = -R; dy <= R; dy++) begin
                for (int dx = -R; dx <= R; dx++) begin
                    w_cx = int'(i_x) + dx;
                    w_cy = int'(i_y) + dy;
                    if (w_cx >= 0 && w_cx < int'(W) && w_cy >= 0 && w_cy < int'(H)) begin
                        o_mask[IDX_W'(w_cy * int'(W) + w_cx)] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/track_canvas.sv
// Handwriting canvas front-end: paints pen samples into a W*H bitmap, hands the
// frozen bitmap to the predictor on submit and waits (with a watchdog) for it
// to finish, optionally clearing afterwards.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of track_canvas_if (pen, clear, submit, predict_finish in;
//                track_input, predict_start, busy, canvas_empty, timeout out)
module track_canvas
    import track_pkg::*;
#(
    parameter int unsigned W          = CANVAS_W,
    parameter int unsigned H          = CANVAS_H,
    parameter int unsigned BRUSH_R    = 1,
    parameter bit          AUTO_CLEAR = 1'b1,
    parameter int unsigned TIMEOUT    = 1048576
) (
    input  logic          clk,
    input  logic          rst_n,
    track_canvas_if.slave bus
);

    localparam int unsigned BITS  = W * H;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    logic [BITS-1:0]  r_bitmap;
    logic             r_predict_start;
    logic             r_busy;
    logic             r_empty;
    logic             r_timeout;
    logic [CNT_W-1:0] r_cnt;

    logic [BITS-1:0]  w_mask;
    logic             w_in_range;
    logic             w_draw;
    logic             w_submit_ok;

    track_brush_mask #(
        .W       (W),
        .H       (H),
        .BRUSH_R (BRUSH_R)
    ) u_brush (
        .i_x        (bus.pen_x),
        .i_y        (bus.pen_y),
        .o_mask     (w_mask),
        .o_in_range (w_in_range)
    );

    // An in-range drawn sample always inks at least its centre pixel.
    assign w_draw      = bus.pen_valid & bus.pen_down & w_in_range;
    // Submit only makes sense if the canvas holds ink after this cycle's write.
    assign w_submit_ok = bus.submit & (~r_empty | w_draw);

    // Controller, bitmap and watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_DRAW;
            r_bitmap        <= '0;
            r_predict_start <= 1'b0;
            r_busy          <= 1'b0;
            r_empty         <= 1'b1;
            r_timeout       <= 1'b0;
            r_cnt           <= '0;
        end else begin
            r_predict_start <= 1'b0;
            case (r_state)
                ST_DRAW: begin
                    if (bus.clear) begin
                        r_bitmap <= '0;
                        r_empty  <= 1'b1;
                    end else begin
                        if (w_draw) begin
                            r_bitmap <= r_bitmap | w_mask;
                            r_empty  <= 1'b0;
                        end
                        if (w_submit_ok) begin
                            r_state         <= ST_SUBMIT;
                            r_predict_start <= 1'b1;
                            r_busy          <= 1'b1;
                        end
                    end
                end
                ST_SUBMIT: begin
                    r_timeout <= 1'b0;
                    r_cnt     <= '0;
                    r_state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Finish takes priority over an expiry in the same cycle.
                    if (bus.predict_finish || r_cnt == CNT_LAST) begin
                        if (!bus.predict_finish) begin
                            r_timeout <= 1'b1;
                        end
                        r_state <= ST_DRAW;
                        r_busy  <= 1'b0;
                        if (AUTO_CLEAR) begin
                            r_bitmap <= '0;
                            r_empty  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_DRAW;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.track_input   = r_bitmap;
    assign bus.predict_start = r_predict_start;
    assign bus.busy          = r_busy;
    assign bus.canvas_empty  = r_empty;
    assign bus.timeout       = r_timeout;

endmodule
